// File: rtl/fir_loop_pkg.sv
// ---------------------------------------------------------------------------
// fir_loop_pkg
// Shared definitions for the DPLL loop-filter FIR:
//   state_t    - controller states (IDLE / MAC / SCALE / OUT)
//   DEF_LIMIT  - default symmetric saturation bound
//   acc_width  - accumulator width that cannot overflow over all taps
//   scl_width  - width of accumulator times unsigned gain (plus sign bit)
// ---------------------------------------------------------------------------
package fir_loop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_LIMIT = 200000;

  // One growth bit per doubling of the tap count keeps the sum exact.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Gain is unsigned, so it gains a zero sign bit before the signed multiply.
  function automatic int scl_width(input int acc_w, input int gain_w);
    return acc_w + gain_w + 1;
  endfunction

endpackage

// File: rtl/fir_loop_filter_if.sv
// ---------------------------------------------------------------------------
// fir_loop_filter_if
// Sample, coefficient-write and result signals of the loop filter.
//   master : drives in_valid/in_data/gain and coef_we/coef_addr/coef_data,
//            observes in_ready, coef_ready, out_valid, out_data, sat_flag
//   slave  : the filter side (directions reversed)
// ---------------------------------------------------------------------------
interface fir_loop_filter_if #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 12,
  parameter int GAIN_W = 8,
  parameter int ADDR_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic        [GAIN_W-1:0] gain;
  logic                     coef_we;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;

  modport master (
    output in_valid, in_data, gain, coef_we, coef_addr, coef_data,
    input  in_ready, coef_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, gain, coef_we, coef_addr, coef_data,
    output in_ready, coef_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/fir_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
// Registered signed multiply-accumulate.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : zero the accumulator (wins over i_en)
//   i_en     : add i_a * i_b into the accumulator
//   i_a, i_b : signed operands
//   o_acc    : accumulator value
// ---------------------------------------------------------------------------
module fir_mac #(
  parameter int A_W   = 12,
  parameter int B_W   = 20,
  parameter int ACC_W = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/fir_loop_filter.sv
// ---------------------------------------------------------------------------
// fir_loop_filter
// Time-multiplexed FIR for the DPLL loop filter: one accepted sample triggers
// TAPS multiply-accumulate cycles over a circular delay line, then a gain /
// shift stage and a symmetric clamp to +-LIMIT.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fir_loop_filter_if.slave (sample handshake, coefficient
//              writes, result with sat_flag)
// A result appears TAPS+2 edges after the accepting edge; a new sample can be
// taken every TAPS+3 cycles.
// ---------------------------------------------------------------------------
module fir_loop_filter
  import fir_loop_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int COEF_W = 12,
  parameter int TAPS   = 29,
  parameter int GAIN_W = 8,
  parameter int SHIFT  = 0,
  parameter int LIMIT  = DEF_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  fir_loop_filter_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int SCL_W = scl_width(ACC_W, GAIN_W);

  localparam logic [AW-1:0]          K_LAST  = AW'(TAPS - 1);
  localparam logic [AW:0]            TAPS_N  = (AW + 1)'(TAPS);
  localparam logic signed [SCL_W-1:0] POS_LIM = SCL_W'(LIMIT);
  localparam logic signed [SCL_W-1:0] NEG_LIM = SCL_W'(-LIMIT);

  state_t r_state, w_state_next;

  logic signed [DATA_W-1:0] r_delay [TAPS];
  logic signed [COEF_W-1:0] r_coef  [TAPS];
  logic [AW-1:0]            r_head;   // next delay-line slot to write
  logic [AW-1:0]            r_rd;     // slot holding x[n-k]
  logic [AW-1:0]            r_k;      // tap index
  logic [GAIN_W-1:0]        r_gain;
  logic signed [SCL_W-1:0]  r_scaled;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_sat;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_coef_wr;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [SCL_W-1:0]  w_acc_x;
  logic signed [SCL_W-1:0]  w_gain_x;
  logic signed [SCL_W-1:0]  w_scaled;
  logic signed [DATA_W-1:0] w_clamped;
  logic                     w_sat;

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = bus.in_valid && w_idle;
  // Writes to addresses past the last tap are discarded.
  assign w_coef_wr = bus.coef_we && w_idle && ({1'b0, bus.coef_addr} < TAPS_N);

  // Controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = MAC;
      MAC:     if (r_k == K_LAST) w_state_next = SCALE;
      SCALE:   w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Delay line and coefficient store. Both are cleared by reset, so they are
  // kept in registers rather than block RAM. A coefficient written in the
  // accept cycle is already visible to the first MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      if (w_accept)  r_delay[r_head]      <= bus.in_data;
      if (w_coef_wr) r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Pointers, gain latch, scale and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_rd        <= '0;
      r_k         <= '0;
      r_gain      <= '0;
      r_scaled    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_head <= (r_head == K_LAST) ? '0 : r_head + 1'b1;
        r_rd   <= r_head;           // newest sample, k = 0
        r_k    <= '0;
        r_gain <= bus.gain;
      end else if (r_state == MAC) begin
        r_k  <= r_k + 1'b1;
        r_rd <= (r_rd == '0) ? K_LAST : r_rd - 1'b1;  // walk back in time
      end
      if (r_state == SCALE) r_scaled <= w_scaled;
      r_out_valid <= (r_state == OUT);
      if (r_state == OUT) begin
        r_out_data <= w_clamped;
        r_sat      <= w_sat;
      end
    end
  end

  fir_mac #(
    .A_W   (COEF_W),
    .B_W   (DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (r_state == MAC),
    .i_a   (r_coef[r_k]),
    .i_b   (r_delay[r_rd]),
    .o_acc (w_acc)
  );

  // Gain is zero-extended so the product stays signed.
  assign w_acc_x  = SCL_W'(w_acc);
  assign w_gain_x = SCL_W'(signed'({1'b0, r_gain}));
  assign w_scaled = (w_acc_x * w_gain_x) >>> SHIFT;

  always_comb begin
    w_sat     = 1'b0;
    w_clamped = r_scaled[DATA_W-1:0];
    if (r_scaled > POS_LIM) begin
      w_clamped = DATA_W'(LIMIT);
      w_sat     = 1'b1;
    end else if (r_scaled < NEG_LIM) begin
      w_clamped = DATA_W'(-LIMIT);
      w_sat     = 1'b1;
    end
  end

  assign bus.in_ready   = w_idle;
  assign bus.coef_ready = w_idle;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.sat_flag   = r_sat;
endmodule
